// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op codes, FSM states and default widths for shift_arbiter
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_LOAD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - registered logical shifter with load/hold, zero-filled shifts
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] s,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o
);

    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_d;

    always_comb begin
        o_d = o_q;
        case (op)
            OP_LOAD: o_d = i;
            OP_SHL:  o_d = o_q << s;
            OP_SHR:  o_d = o_q >> s;
            default: o_d = o_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign o = o_q;

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester round-robin front end sharing one shift_core
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_dir,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_dir,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             busy,
    output logic [15:0]      op_count
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             last_q;
    logic             id_q;
    logic             dir_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    logic [15:0]      op_count_q;
    logic [15:0]      op_count_d;

    logic             grant;
    logic             idle;
    logic             in_resp;
    logic             accept;
    logic             rsp_hs;
    logic [1:0]       core_op;
    logic [WIDTH-1:0] core_o;

    // With a single requester valid it wins outright; on contention the one
    // not granted last wins. last_q resets to 1 so requester 0 goes first.
    assign grant = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;

    // Outputs are gated by rst so nothing leaks out during reset cycles,
    // even on the first cycle when state_q still holds a stale state.
    assign idle    = (state_q == ST_IDLE) && !rst;
    assign in_resp = (state_q == ST_RESP) && !rst;

    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign rsp0_valid = in_resp && !id_q;
    assign rsp1_valid = in_resp && id_q;
    assign rsp0_data  = rsp0_valid ? core_o : '0;
    assign rsp1_data  = rsp1_valid ? core_o : '0;
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign busy     = (state_q != ST_IDLE) && !rst;
    assign op_count = op_count_q;

    always_comb begin
        state_d    = state_q;
        core_op    = OP_HOLD;
        op_count_d = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_op = OP_LOAD;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (amt_q == '0) begin
                    core_op = OP_HOLD;
                end else if (dir_q) begin
                    core_op = OP_SHR;
                end else begin
                    core_op = OP_SHL;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d    = ST_IDLE;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            op_count_q <= op_count_d;
        end
    end

    // Operands are captured once at accept; the requester may change its
    // inputs freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            id_q   <= 1'b0;
            dir_q  <= 1'b0;
            data_q <= '0;
            amt_q  <= '0;
        end else if (accept) begin
            last_q <= grant;
            id_q   <= grant;
            dir_q  <= grant ? req1_dir  : req0_dir;
            data_q <= grant ? req1_data : req0_data;
            amt_q  <= grant ? req1_amt  : req0_amt;
        end
    end

    shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .op  (core_op),
        .s   (amt_q),
        .i   (data_q),
        .o   (core_o)
    );

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - randomized and directed checks of shift_arbiter against a transaction model
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_dir, rsp0_valid, rsp0_ready;
    logic [7:0] req0_data, rsp0_data;
    logic [2:0] req0_amt;
    logic       req1_valid, req1_ready, req1_dir, rsp1_valid, rsp1_ready;
    logic [7:0] req1_data, rsp1_data;
    logic [2:0] req1_amt;
    logic       busy;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    // transaction model: one op in flight, age counts cycles since accept
    bit m_busy;
    int m_age;
    bit m_id;
    int m_res;
    bit m_last;
    int m_count;

    // observations from the most recent step
    bit         obs_v0, obs_v1, obs_r0, obs_r1;
    logic [7:0] obs_d0, obs_d1;
    int         acc_id;
    int         step_no = 0;
    int         acc_ids[$];
    int         acc_steps[$];

    always #5 clk = ~clk;

    shift_arbiter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int shift_ref(input int d, input int a, input bit dir);
        if (dir) return d / (1 << a);
        return (d * (1 << a)) % 256;
    endfunction

    task automatic step(input bit r,
                        input bit v0, input logic [7:0] d0, input logic [2:0] a0, input bit dir0,
                        input bit v1, input logic [7:0] d1, input logic [2:0] a1, input bit dir1,
                        input bit rr0, input bit rr1);
        bit g, idle, e_r0, e_r1, e_v0, e_v1;
        rst = r;
        req0_valid = v0; req0_data = d0; req0_amt = a0; req0_dir = dir0;
        req1_valid = v1; req1_data = d1; req1_amt = a1; req1_dir = dir1;
        rsp0_ready = rr0; rsp1_ready = rr1;
        #1;
        g    = (v0 && v1) ? !m_last : !v0;
        idle = !m_busy && !r;
        e_r0 = idle && v0 && !g;
        e_r1 = idle && v1 && g;
        e_v0 = !r && m_busy && m_age >= 3 && !m_id;
        e_v1 = !r && m_busy && m_age >= 3 && m_id;
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp0_valid", rsp0_valid, e_v0);
        chk("rsp1_valid", rsp1_valid, e_v1);
        chk("busy", busy, !r && m_busy);
        if (!r) chk("op_count", op_count, m_count);
        if (e_v0) chk("rsp0_data", rsp0_data, m_res);
        if (e_v1) chk("rsp1_data", rsp1_data, m_res);
        if (e_v1) chk("rsp0_data_idle", rsp0_data, 0);
        if (e_v0) chk("rsp1_data_idle", rsp1_data, 0);
        obs_v0 = rsp0_valid; obs_v1 = rsp1_valid;
        obs_d0 = rsp0_data;  obs_d1 = rsp1_data;
        obs_r0 = req0_ready; obs_r1 = req1_ready;
        acc_id = -1;
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_last = 1; m_count = 0; m_age = 0;
        end else if (e_r0 || e_r1) begin
            m_busy = 1; m_age = 1; m_id = g; m_last = g;
            m_res  = g ? shift_ref(d1, a1, dir1) : shift_ref(d0, a0, dir0);
            acc_id = g ? 1 : 0;
        end else if (m_busy) begin
            if ((e_v0 && rr0) || (e_v1 && rr1)) begin
                m_busy = 0;
                m_count = (m_count + 1) % 65536;
            end else begin
                m_age++;
            end
        end
        step_no++;
        @(negedge clk);
    endtask

    task automatic idle_step(input bit rr);
        step(0, 0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, rr, rr);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_data = 0; req0_amt = 0; req0_dir = 0;
        req1_valid = 0; req1_data = 0; req1_amt = 0; req1_dir = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        m_busy = 0; m_last = 1; m_count = 0; m_age = 0; m_id = 0; m_res = 0;

        // reset with requests pending: nothing may be granted
        step(1, 1, 8'h11, 3'd1, 0, 1, 8'h22, 3'd2, 1, 1, 1);
        step(1, 1, 8'h11, 3'd1, 0, 1, 8'h22, 3'd2, 1, 1, 1);
        chk("reset_cnt", op_count, 0);
        chk("reset_busy", busy, 0);

        // req0 0x81 << 1
        step(0, 1, 8'h81, 3'd1, 0, 0, 8'h00, 3'd0, 0, 1, 1);
        idle_step(1);
        idle_step(1);
        chk("t3_rsp0_valid_early", obs_v0, 0);
        idle_step(1);
        chk("t3_rsp0_valid", obs_v0, 1);
        chk("t3_rsp0_data", obs_d0, 8'h02);
        chk("t3_cnt", op_count, 1);

        // req1 0x81 >> 3, inputs scrambled after accept
        step(0, 0, 8'h00, 3'd0, 0, 1, 8'h81, 3'd3, 1, 1, 1);
        step(0, 0, 8'h00, 3'd0, 0, 0, 8'hFF, 3'd7, 0, 1, 1);
        idle_step(1);
        idle_step(1);
        chk("r1_rsp1_valid", obs_v1, 1);
        chk("r1_rsp1_data", obs_d1, 8'h10);
        chk("r1_rsp0_valid", obs_v0, 0);

        // round robin under continuous contention after reset
        step(1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, 1);
        acc_ids.delete(); acc_steps.delete();
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 8'($urandom), 3'($urandom), 1'($urandom),
                    1, 8'($urandom), 3'($urandom), 1'($urandom), 1, 1);
            if (acc_id >= 0) begin
                acc_ids.push_back(acc_id);
                acc_steps.push_back(k);
            end
        end
        chk("rr_count", acc_ids.size(), 4);
        for (int k = 0; k < 4 && k < acc_ids.size(); k++) begin
            chk("rr_order", acc_ids[k], k % 2);
            chk("rr_spacing", acc_steps[k], 4 * k);
        end

        // amt 0 hold with backpressure; requester 1 must stay stalled
        step(0, 1, 8'hA5, 3'd0, 0, 1, 8'h3C, 3'd2, 0, 0, 1);
        step(0, 0, 8'h00, 3'd5, 1, 1, 8'h3C, 3'd2, 0, 0, 1);
        step(0, 0, 8'h00, 3'd5, 1, 1, 8'h3C, 3'd2, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 8'h00, 3'd5, 1, 1, 8'h3C, 3'd2, 0, 0, 1);
            chk("bp_rsp0_valid", obs_v0, 1);
            chk("bp_rsp0_data", obs_d0, 8'hA5);
            chk("bp_req1_ready", obs_r1, 0);
        end
        step(0, 0, 8'h00, 3'd5, 1, 1, 8'h3C, 3'd2, 0, 1, 1);
        for (int k = 0; k < 5; k++) idle_step(1);

        // reset while in SHIFT
        step(0, 1, 8'hF0, 3'd2, 0, 0, 8'h00, 3'd0, 0, 1, 1);
        idle_step(1);
        step(1, 0, 8'h00, 3'd0, 0, 0, 8'h00, 3'd0, 0, 1, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", op_count, 0);
        chk("mid_rst_core", dut.core_o, 0);
        chk("mid_rst_v0", rsp0_valid, 0);
        for (int k = 0; k < 4; k++) begin
            idle_step(1);
            chk("post_rst_v0", obs_v0, 0);
        end

        // op_count wrap
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.op_count_q;
        m_count = 65535;
        chk("wrap_pre", op_count, 16'hFFFF);
        step(0, 0, 8'h00, 3'd0, 0, 1, 8'h0F, 3'd1, 0, 1, 1);
        idle_step(1);
        idle_step(1);
        idle_step(1);
        chk("wrap_post", op_count, 16'h0000);

        // randomized traffic with occasional reset
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 9) < 7, 8'($urandom), 3'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 7, 8'($urandom), 3'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; AMT_W, default 3, shift-amount width (log2 WIDTH).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_data  in  WIDTH  operand.
- req0_amt  in  AMT_W  shift amount.
- req0_dir  in  1  0 = left, 1 = right.
- rsp0_valid  out  1  requester 0 result valid.
- rsp0_ready  in  1  requester 0 result consumed.
- rsp0_data  out  WIDTH  shifted result.
- req1_* / rsp1_*  same as requester 0, for requester 1.
- busy  out  1  high in every state except IDLE.
- op_count  out  16  completed operations, wraps.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SHIFT, RESP; transitions: IDLE->LOAD on accept; LOAD->SHIFT; SHIFT->RESP; RESP->IDLE on rsp handshake of the granted requester.
REQ-004 In IDLE, reqN_ready SHALL be high only for the granted requester while reqN_valid is high; both readys SHALL be low in all other states.
REQ-005 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last; last-grant pointer SHALL update on every accept.
REQ-006 On accept, data, amt, dir and requester id SHALL be captured; later requester input changes SHALL NOT affect the operation.
REQ-007 In LOAD, the shifter SHALL be driven with op LOAD and the captured data.
REQ-008 In SHIFT, the shifter SHALL be driven with op SHL (dir=0) or SHR (dir=1) and s = amt; amt = 0 SHALL drive op HOLD.
REQ-009 In IDLE and RESP, the shifter op SHALL be HOLD.
REQ-010 Shifts SHALL be logical, zero-filled, result truncated to WIDTH bits.
REQ-011 Latency: accept at cycle T -> LOAD at T+1, SHIFT at T+2, rspN_valid high at T+3.
REQ-012 In RESP, only the granted requester's rsp_valid SHALL be high; rsp_data SHALL equal the shifter output and SHALL hold stable until rsp_ready.
REQ-013 The other requester's rsp_data SHALL be 0.
REQ-014 A RESP handshake SHALL increment op_count by 1, with 0xFFFF wrapping to 0x0000.
REQ-015 A new accept SHALL be possible in the cycle after a RESP handshake; minimum spacing is 4 cycles per operation.
REQ-016 reqN_valid deasserting before acceptance SHALL be legal and SHALL cause no action.

Reset
REQ-017 While rst is high at a clock edge: state = IDLE, last-grant pointer = requester 1 (so requester 0 wins first), captured registers = 0, shifter output = 0, op_count = 0.
REQ-018 During reset cycles, all reqN_ready, rspN_valid and busy SHALL be 0.
REQ-019 Reset in any state SHALL abandon the in-flight operation, emit no response, and leave op_count at 0.

Structure
REQ-020 Package shift_pkg SHALL hold: shifter op codes HOLD=2'b00, SHL=2'b01, SHR=2'b10, LOAD=2'b11; the FSM state enum; the WIDTH/AMT_W defaults.
REQ-021 The shifter SHALL be a separate sub-module, shift_core, instantiated once:
- registered WIDTH-bit output with sync reset;
- ports clk, rst, op, s, i, o;
- case-based decode with no loops, no delays, and a default branch that holds.

Verification
REQ-022 req0 0x81, amt 1, left, accepted at T -> rsp0_valid at T+3 with rsp0_data = 0x02, and op_count = 1 after the handshake.
REQ-023 req1 0x81, amt 3, right -> rsp1_data = 0x10; rsp0_valid stays 0 throughout.
REQ-024 After reset, both requesters valid continuously -> grants in order 0, 1, 0, 1; each operation spans 4 cycles with rsp_ready tied high.
REQ-025 req0 0xA5, amt 0, with rsp0_ready low for 5 cycles -> rsp0_valid and rsp0_data = 0xA5 stay stable, and req1_ready stays 0 until the handshake.
REQ-026 rst pulsed for one cycle while in SHIFT -> next cycle state IDLE, busy = 0, no rsp_valid, op_count = 0, shifter output = 0.
REQ-027 Force op_count to 0xFFFF, then complete one operation -> op_count = 0x0000.
